stream_sum_accumulator: RTL and testbench
=========================================

Name: stream_sum_accumulator

Overview:
Consumes a valid/ready stream of WIDTH-bit unsigned operands grouped into packets (in_last marks the final beat). Accumulates each packet's sum through one carry_select_adder instance and presents the packet total with a sticky overflow flag and a beat count on a valid/ready result port. Sits directly downstream of the operand source, wrapping the combinational adder with registered state and handshakes.

Parameters:
WIDTH, 32, operand/accumulator width in bits
CNT_WIDTH, 8, beat counter width; the counter saturates at 2^CNT_WIDTH-1

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
clear  input  1  synchronous abort: drop the current packet or result
in_data  input  WIDTH  operand
in_valid  input  1  operand valid
in_last  input  1  final beat of the packet, qualified by in_valid
in_ready  output  1  block accepts an operand this cycle
out_sum  output  WIDTH  packet sum modulo 2^WIDTH
out_ovf  output  1  at least one carry-out occurred during the packet
out_count  output  CNT_WIDTH  beats accepted in the packet, saturating
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result

Behaviour:
- States: ACCUM and DONE. Reset enters ACCUM with acc=0, ovf=0, cnt=0, out_valid=0, in_ready=1. out_sum, out_ovf and out_count are driven directly from acc, ovf and cnt, so they read 0 after reset.
- ACCUM: in_ready=1 and out_valid=0. A beat is accepted when in_valid&&in_ready. On a beat:
  - acc <= adder.sum, computed as acc + in_data with cin=0.
  - ovf <= ovf | adder.cout.
  - cnt <= cnt+1, holding at all-ones once saturated.
  - If in_last is set, the next state is DONE.
- Latency: the result is visible with out_valid=1 on the cycle after the in_last beat.
- DONE: in_ready=0 and out_valid=1. out_sum, out_ovf and out_count stay stable until the handshake. On out_valid&&out_ready, the block clears acc, ovf and cnt to 0 and returns to ACCUM. This leaves a one-cycle bubble before the next operand is accepted; there is no same-cycle pass-through.
- in_valid without a handshake in DONE is ignored. in_last is ignored unless the beat is accepted.
- Single-beat packet (first beat has in_last=1): out_sum=in_data, out_count=1.
- Wrap-around: the sum wraps modulo 2^WIDTH. ovf is sticky for the packet and is never cleared by a later beat without a carry.
- clear (any state): next cycle the block is in ACCUM with acc, ovf and cnt at 0 and out_valid=0. clear takes priority over a simultaneous input beat, which is dropped, and over a simultaneous output handshake, which counts as not delivered.
- rst mid-packet or in DONE: same as clear; all state returns to reset values on the next edge.
- The adder is purely combinational between the acc register and the acc input. There is no other arithmetic path.

Decomposition:
- Shared package: state encoding constants ST_ACCUM and ST_DONE, and the default WIDTH and CNT_WIDTH.
- One sub-module: carry_select_adder (existing block), instantiated with WIDTH, a=acc, b=in_data, cin=1'b0.
- FSM, counter and flag logic stay in this module.

Test Plan:
- Packet 5, 7, 10 (last on 10), out_ready=1 -> out_valid one cycle after the 10 beat; out_sum=22, out_ovf=0, out_count=3; in_ready=0 for exactly one cycle.
- WIDTH=32: packet 0xFFFF_FFFF, 0x0000_0002, then 0x0000_0001 (last) -> out_sum=0x0000_0002, out_ovf=1 (sticky across the final beat), out_count=3.
- Result backpressure: packet 3 (single beat, last), out_ready=0 for 4 cycles while in_valid=1 with new data -> out_sum=3 stable; in_ready=0; no beats accepted until the handshake, then the next packet starts from acc=0.
- clear asserted on the cycle of a mid-packet beat 9 after beats 1 and 2 -> beat dropped; next packet 4 (last) gives out_sum=4, out_count=1.
- CNT_WIDTH=2: packet of 6 beats of value 1 -> out_count=3 (saturated), out_sum=6.
- rst pulsed while in DONE -> next cycle out_valid=0, in_ready=1, out_sum=0, out_ovf=0, out_count=0.

Source files
------------

// File: rtl/stream_sum_accumulator_pkg.sv
// Shared types and defaults for the packet sum accumulator and its adder.
package stream_sum_accumulator_pkg;

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } state_e;

   localparam int unsigned DEF_WIDTH     = 32;
   localparam int unsigned DEF_CNT_WIDTH = 8;
   localparam int unsigned CSA_BLOCK     = 8;

endpackage

// File: rtl/stream_sum_accumulator_adder.sv
// Combinational carry-select adder: each block precomputes sums for both
// carry-in values and the rippling block carry picks one.
module carry_select_adder
   import stream_sum_accumulator_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned BLOCK = CSA_BLOCK
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned NBLK = (WIDTH + BLOCK - 1) / BLOCK;
   localparam int unsigned PW   = NBLK * BLOCK;

   logic [PW-1:0] a_pad;
   logic [PW-1:0] b_pad;
   logic [PW-1:0] s_pad;
   logic [NBLK:0] c;
   logic [PW:0]   s_full;

   // Zero padding keeps the carry out of bit WIDTH-1 visible at s_full[WIDTH].
   always_comb begin
      a_pad = '0;
      b_pad = '0;
      a_pad[WIDTH-1:0] = a;
      b_pad[WIDTH-1:0] = b;
   end

   assign c[0] = cin;

   for (genvar i = 0; i < NBLK; i++) begin : g_blk
      logic [BLOCK:0] s0;
      logic [BLOCK:0] s1;

      assign s0 = {1'b0, a_pad[i*BLOCK +: BLOCK]} + {1'b0, b_pad[i*BLOCK +: BLOCK]};
      assign s1 = {1'b0, a_pad[i*BLOCK +: BLOCK]} + {1'b0, b_pad[i*BLOCK +: BLOCK]}
                  + (BLOCK+1)'(1);

      assign s_pad[i*BLOCK +: BLOCK] = c[i] ? s1[BLOCK-1:0] : s0[BLOCK-1:0];
      assign c[i+1]                  = c[i] ? s1[BLOCK]     : s0[BLOCK];
   end

   assign s_full = {c[NBLK], s_pad};
   assign sum    = s_full[WIDTH-1:0];
   assign cout   = s_full[WIDTH];

endmodule

// File: rtl/stream_sum_accumulator.sv
// Sums each valid/ready operand packet and holds the total, sticky carry flag
// and saturating beat count on a valid/ready result port until taken.
module stream_sum_accumulator
   import stream_sum_accumulator_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_valid,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic [WIDTH-1:0]     out_sum,
   output logic                 out_ovf,
   output logic [CNT_WIDTH-1:0] out_count,
   output logic                 out_valid,
   input  logic                 out_ready
);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic                 ovf_q, ovf_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0]     add_sum;
   logic                 add_cout;
   logic                 beat;

   carry_select_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a    (acc_q),
      .b    (in_data),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      cnt_d     = cnt_q;
      in_ready  = (state_q == ST_ACCUM);
      out_valid = (state_q == ST_DONE);
      beat      = in_valid && in_ready;

      case (state_q)
         ST_ACCUM: begin
            if (beat) begin
               acc_d = add_sum;
               ovf_d = ovf_q | add_cout;
               cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
               if (in_last) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_ACCUM;
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase

      // Abort wins over any beat or result handshake in the same cycle.
      if (clear) begin
         acc_d   = '0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
         state_d = ST_ACCUM;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACCUM;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_sum   = acc_q;
   assign out_ovf   = ovf_q;
   assign out_count = cnt_q;

endmodule

// File: tb/tb_stream_sum_accumulator.sv
// Bench for stream_sum_accumulator: directed cases then random packets,
// driving a default instance and a 2-bit-counter instance in lockstep.
module tb_stream_sum_accumulator;

   logic        clk;
   logic        rst;
   logic        clear;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic        out_ready;

   logic        in_ready_a,  out_valid_a, out_ovf_a;
   logic [31:0] out_sum_a;
   logic [7:0]  out_count_a;
   logic        in_ready_b,  out_valid_b, out_ovf_b;
   logic [31:0] out_sum_b;
   logic [1:0]  out_count_b;

   int unsigned checks = 0;
   int unsigned passed = 0;
   int unsigned fails  = 0;

   logic [31:0] pkt[$];

   stream_sum_accumulator dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready_a),
      .out_sum   (out_sum_a),
      .out_ovf   (out_ovf_a),
      .out_count (out_count_a),
      .out_valid (out_valid_a),
      .out_ready (out_ready)
   );

   stream_sum_accumulator #(.CNT_WIDTH(2)) dut_sat (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready_b),
      .out_sum   (out_sum_b),
      .out_ovf   (out_ovf_b),
      .out_count (out_count_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"},   out_valid_a, 1'b0);
      chk({tag, "_ready"},   in_ready_a,  1'b1);
      chk({tag, "_sum"},     out_sum_a,   0);
      chk({tag, "_ovf"},     out_ovf_a,   1'b0);
      chk({tag, "_count"},   out_count_a, 0);
      chk({tag, "_valid_b"}, out_valid_b, 1'b0);
      chk({tag, "_count_b"}, out_count_b, 0);
   endtask

   // Reference: exact wide sum of the packet; a carry happened iff it reached 2^32.
   task automatic chk_result(input string tag);
      longint unsigned total = 0;
      int unsigned     n     = pkt.size();
      foreach (pkt[i]) total += pkt[i];
      chk({tag, "_valid"},   out_valid_a, 1'b1);
      chk({tag, "_ready"},   in_ready_a,  1'b0);
      chk({tag, "_sum"},     out_sum_a,   total % 64'h1_0000_0000);
      chk({tag, "_ovf"},     out_ovf_a,   total >= 64'h1_0000_0000);
      chk({tag, "_count"},   out_count_a, (n > 255) ? 255 : n);
      chk({tag, "_valid_b"}, out_valid_b, 1'b1);
      chk({tag, "_sum_b"},   out_sum_b,   total % 64'h1_0000_0000);
      chk({tag, "_count_b"}, out_count_b, (n > 3) ? 3 : n);
   endtask

   task automatic send_packet(input string tag, input bit gaps);
      for (int i = 0; i < pkt.size(); i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               in_last  = $urandom_range(0, 1);
               in_data  = $urandom;
               tick();
            end
         end
         in_data  = pkt[i];
         in_valid = 1'b1;
         in_last  = (i == pkt.size() - 1);
         chk({tag, "_beat_ready"}, in_ready_a,  1'b1);
         chk({tag, "_beat_valid"}, out_valid_a, 1'b0);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk_result(tag);
   endtask

   task automatic recv_result(input string tag, input int unsigned hold);
      logic [31:0] held = out_sum_a;
      repeat (hold) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         in_data   = $urandom;
         in_last   = $urandom_range(0, 1);
         tick();
         chk({tag, "_hold_valid"}, out_valid_a, 1'b1);
         chk({tag, "_hold_ready"}, in_ready_a,  1'b0);
         chk({tag, "_hold_sum"},   out_sum_a,   held);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk_idle({tag, "_after"});
   endtask

   initial begin
      rst       = 1'b1;
      clear     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_idle("reset");

      pkt = '{32'd5, 32'd7, 32'd10};
      send_packet("basic", 1'b0);
      recv_result("basic", 0);

      pkt = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
      send_packet("wrap", 1'b0);
      recv_result("wrap", 0);

      pkt = '{32'd3};
      send_packet("bp", 1'b0);
      recv_result("bp", 4);
      pkt = '{32'd11, 32'd20};
      send_packet("after_bp", 1'b0);
      recv_result("after_bp", 1);

      // Mid-packet abort: beat 9 collides with clear and must be dropped.
      pkt = '{32'd1, 32'd2};
      foreach (pkt[i]) begin
         in_data  = pkt[i];
         in_valid = 1'b1;
         in_last  = 1'b0;
         tick();
      end
      in_data = 32'd9;
      clear   = 1'b1;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      chk_idle("clear");
      pkt = '{32'd4};
      send_packet("post_clear", 1'b0);

      // Abort while a result is offered and taken in the same cycle.
      out_ready = 1'b1;
      clear     = 1'b1;
      tick();
      clear     = 1'b0;
      out_ready = 1'b0;
      chk_idle("clear_done");

      pkt = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
      send_packet("sat", 1'b0);
      recv_result("sat", 0);

      pkt = '{32'd100, 32'hFFFF_FF00};
      send_packet("rst_done", 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_idle("rst_done");

      for (int p = 0; p < 30; p++) begin
         int unsigned len = $urandom_range(1, 10);
         pkt = {};
         for (int i = 0; i < len; i++) begin
            pkt.push_back($urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 1000)));
         end
         send_packet("rand", 1'b1);
         recv_result("rand", $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
